// File: rtl/axis_chk_pkg.sv
// Shared codes, FSM encoding and helpers for the AXI-stream outbound checker.
package axis_chk_pkg;

    localparam logic [7:0] TU_NONE = 8'h00;
    localparam logic [7:0] TU_SOT  = 8'h01;
    localparam logic [7:0] TU_EOT  = 8'h02;
    localparam logic [7:0] TU_MID  = 8'h03;

    localparam logic [7:0] OP_CQE   = 8'h09;
    localparam logic [7:0] OP_STATS = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_CQE   = 2'd2,
        ST_STATS = 2'd3
    } frame_state_e;

    // Bit positions inside the 4-bit mismatch mask {last,strb,user,data}.
    localparam int unsigned F_DATA     = 0;
    localparam int unsigned F_USER     = 1;
    localparam int unsigned F_STRB     = 2;
    localparam int unsigned F_LAST     = 3;
    localparam int unsigned NUM_FIELDS = 4;

    // Frame context that travels with a beat into the compare stage.
    typedef struct packed {
        logic exp_last;
        logic mask_data;
        logic is_eot;
    } chk_ctx_t;

    function automatic logic [2:0] popcount4(input logic [NUM_FIELDS-1:0] m);
        popcount4 = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction

endpackage

// File: rtl/axis_chk_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used for backpressure.
module axis_chk_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic feedback;

    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/axis_stream_checker.sv
// Outbound AXI-stream checker: compares DUT beats against an expected stream,
// derives tlast from frame context, and keeps error/progress status.
module axis_stream_checker
    import axis_chk_pkg::*;
#(
    parameter int unsigned DWIDTH     = 64,
    parameter int unsigned TSTRB_W    = DWIDTH / 8,
    parameter int unsigned TUSER_W    = 8,
    parameter int unsigned WDOG_LIMIT = 10000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               act_tvalid,
    input  logic [DWIDTH-1:0]  act_tdata,
    input  logic [TSTRB_W-1:0] act_tstrb,
    input  logic [TUSER_W-1:0] act_tuser,
    input  logic               act_tlast,
    output logic               act_tready,

    input  logic               exp_tvalid,
    input  logic [DWIDTH-1:0]  exp_tdata,
    input  logic [TSTRB_W-1:0] exp_tstrb,
    input  logic [TUSER_W-1:0] exp_tuser,
    output logic               exp_tready,
    input  logic               exp_done,

    input  logic [7:0]         cfg_bp_thresh,
    input  logic               cfg_mask_stats_eot,
    input  logic               clear,

    output logic [15:0]        err_cnt,
    output logic [31:0]        beat_cnt,
    output logic [15:0]        frame_cnt,
    output logic               first_err_valid,
    output logic [31:0]        first_err_beat,
    output logic [3:0]         first_err_fields,
    output logic               wdog_expired,
    output logic               extra_beat,
    output logic               done,
    output logic               pass
);

    localparam int unsigned WDOG_W  = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);
    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    logic [15:0]        lfsr;
    logic               bp_allow;
    logic               beat;
    logic               is_sot;
    logic               is_eot;
    logic [7:0]         opcode;
    frame_state_e       state;
    chk_ctx_t           ctx_c;

    logic               s1_valid;
    logic [DWIDTH-1:0]  s1_act_data;
    logic [TSTRB_W-1:0] s1_act_strb;
    logic [TUSER_W-1:0] s1_act_user;
    logic               s1_act_last;
    logic [DWIDTH-1:0]  s1_exp_data;
    logic [TSTRB_W-1:0] s1_exp_strb;
    logic [TUSER_W-1:0] s1_exp_user;
    chk_ctx_t           s1_ctx;

    logic [NUM_FIELDS-1:0] mism_c;
    logic                  s2_valid;
    logic [NUM_FIELDS-1:0] s2_mask;
    logic                  s2_is_eot;

    logic [16:0]        err_sum_c;
    logic [WDOG_W-1:0]  wdog_cnt;
    logic               done_c;

    axis_chk_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr)
    );

    // Handshake: ready only when an expectation is waiting and the LFSR allows it.
    assign bp_allow   = lfsr[7:0] >= cfg_bp_thresh;
    assign act_tready = exp_tvalid & bp_allow;
    assign exp_tready = act_tvalid & act_tready;
    assign beat       = exp_tready;

    // The expected stream defines frame context.
    assign is_sot = exp_tuser == TUSER_W'(TU_SOT);
    assign is_eot = exp_tuser == TUSER_W'(TU_EOT);
    assign opcode = exp_tdata[7:0];

    always_comb begin
        ctx_c           = '0;
        ctx_c.exp_last  = (is_eot && state == ST_CQE) ||
                          (is_sot && is_eot && opcode == OP_CQE);
        ctx_c.mask_data = is_eot && state == ST_STATS && cfg_mask_stats_eot;
        ctx_c.is_eot    = is_eot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else if (beat) begin
            if (is_sot) begin
                if (opcode == OP_CQE) begin
                    state <= ST_CQE;
                end else if (opcode == OP_STATS) begin
                    state <= ST_STATS;
                end else begin
                    state <= ST_FRAME;
                end
            end else if (is_eot) begin
                state <= ST_IDLE;
            end
        end
    end

    // Stage 1: capture the beat pair and its context; clear drops the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_act_data <= '0;
            s1_act_strb <= '0;
            s1_act_user <= '0;
            s1_act_last <= 1'b0;
            s1_exp_data <= '0;
            s1_exp_strb <= '0;
            s1_exp_user <= '0;
            s1_ctx      <= '0;
        end else begin
            s1_valid <= beat && !clear;
            if (beat) begin
                s1_act_data <= act_tdata;
                s1_act_strb <= act_tstrb;
                s1_act_user <= act_tuser;
                s1_act_last <= act_tlast;
                s1_exp_data <= exp_tdata;
                s1_exp_strb <= exp_tstrb;
                s1_exp_user <= exp_tuser;
                s1_ctx      <= ctx_c;
            end
        end
    end

    always_comb begin
        mism_c         = '0;
        mism_c[F_DATA] = (s1_act_data !== s1_exp_data) && !s1_ctx.mask_data;
        mism_c[F_USER] = s1_act_user !== s1_exp_user;
        mism_c[F_STRB] = s1_act_strb !== s1_exp_strb;
        mism_c[F_LAST] = s1_act_last !== s1_ctx.exp_last;
    end

    // Stage 2: register the mismatch mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_mask   <= '0;
            s2_is_eot <= 1'b0;
        end else begin
            s2_valid  <= s1_valid && !clear;
            s2_mask   <= mism_c;
            s2_is_eot <= s1_ctx.is_eot;
        end
    end

    assign err_sum_c = {1'b0, err_cnt} + 17'(popcount4(s2_mask));

    // Stage 3: status counters and first-error capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt          <= '0;
            beat_cnt         <= '0;
            frame_cnt        <= '0;
            first_err_valid  <= 1'b0;
            first_err_beat   <= '0;
            first_err_fields <= '0;
        end else if (clear) begin
            err_cnt          <= '0;
            beat_cnt         <= '0;
            frame_cnt        <= '0;
            first_err_valid  <= 1'b0;
            first_err_beat   <= '0;
            first_err_fields <= '0;
        end else if (s2_valid) begin
            err_cnt  <= err_sum_c[16] ? ERR_MAX : err_sum_c[15:0];
            beat_cnt <= beat_cnt + 32'd1;
            if (s2_is_eot) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (|s2_mask && !first_err_valid) begin
                first_err_valid  <= 1'b1;
                first_err_beat   <= beat_cnt;
                first_err_fields <= s2_mask;
            end
        end
    end

    // Watchdog counts stalled cycles with an expectation pending and freezes on expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt     <= '0;
            wdog_expired <= 1'b0;
        end else if (clear) begin
            wdog_cnt     <= '0;
            wdog_expired <= 1'b0;
        end else if (!wdog_expired) begin
            if (beat) begin
                wdog_cnt <= '0;
            end else if (exp_tvalid) begin
                if (wdog_cnt >= WDOG_W'(WDOG_LIMIT - 1)) begin
                    wdog_cnt     <= WDOG_W'(WDOG_LIMIT);
                    wdog_expired <= 1'b1;
                end else begin
                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            extra_beat <= 1'b0;
        end else if (clear) begin
            extra_beat <= 1'b0;
        end else if (act_tvalid && exp_done && !exp_tvalid) begin
            extra_beat <= 1'b1;
        end
    end

    assign done_c = (exp_done && !exp_tvalid && !s1_valid && !s2_valid) || wdog_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= done_c;
            pass <= done_c && err_cnt == 16'd0 && !wdog_expired && !extra_beat;
        end
    end

endmodule

// File: tb/tb_axis_stream_checker.sv
// Randomized self-checking bench for axis_stream_checker with a frame-level reference model.
`timescale 1ns/1ps
module tb_axis_stream_checker;
    import axis_chk_pkg::*;

    localparam int unsigned DW   = 64;
    localparam int unsigned SW   = 8;
    localparam int unsigned UW   = 8;
    localparam int unsigned WDOG = 16;

    localparam int K_NONE  = 0;
    localparam int K_FRAME = 1;
    localparam int K_CQE   = 2;
    localparam int K_STATS = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          act_tvalid;
    logic [DW-1:0] act_tdata;
    logic [SW-1:0] act_tstrb;
    logic [UW-1:0] act_tuser;
    logic          act_tlast;
    logic          act_tready;
    logic          exp_tvalid;
    logic [DW-1:0] exp_tdata;
    logic [SW-1:0] exp_tstrb;
    logic [UW-1:0] exp_tuser;
    logic          exp_tready;
    logic          exp_done;
    logic [7:0]    cfg_bp_thresh;
    logic          cfg_mask_stats_eot;
    logic          clear;
    logic [15:0]   err_cnt;
    logic [31:0]   beat_cnt;
    logic [15:0]   frame_cnt;
    logic          first_err_valid;
    logic [31:0]   first_err_beat;
    logic [3:0]    first_err_fields;
    logic          wdog_expired;
    logic          extra_beat;
    logic          done;
    logic          pass;

    always #5 clk = ~clk;

    axis_stream_checker #(
        .DWIDTH     (DW),
        .TSTRB_W    (SW),
        .TUSER_W    (UW),
        .WDOG_LIMIT (WDOG),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .act_tvalid         (act_tvalid),
        .act_tdata          (act_tdata),
        .act_tstrb          (act_tstrb),
        .act_tuser          (act_tuser),
        .act_tlast          (act_tlast),
        .act_tready         (act_tready),
        .exp_tvalid         (exp_tvalid),
        .exp_tdata          (exp_tdata),
        .exp_tstrb          (exp_tstrb),
        .exp_tuser          (exp_tuser),
        .exp_tready         (exp_tready),
        .exp_done           (exp_done),
        .cfg_bp_thresh      (cfg_bp_thresh),
        .cfg_mask_stats_eot (cfg_mask_stats_eot),
        .clear              (clear),
        .err_cnt            (err_cnt),
        .beat_cnt           (beat_cnt),
        .frame_cnt          (frame_cnt),
        .first_err_valid    (first_err_valid),
        .first_err_beat     (first_err_beat),
        .first_err_fields   (first_err_fields),
        .wdog_expired       (wdog_expired),
        .extra_beat         (extra_beat),
        .done               (done),
        .pass               (pass)
    );

    int total = 0;
    int bad   = 0;

    beat_t eq[$];
    beat_t aq[$];
    int    valid_cycles;
    int    bp_low_cycles;

    // Reference model state: frame kind in progress plus accumulated status.
    int         m_err;
    int         m_beats;
    int         m_frames;
    bit         m_fv;
    int         m_fbeat;
    logic [3:0] m_ffields;
    int         m_kind;

    function automatic void model_reset();
        m_err     = 0;
        m_beats   = 0;
        m_frames  = 0;
        m_fv      = 1'b0;
        m_fbeat   = 0;
        m_ffields = 4'h0;
        m_kind    = K_NONE;
    endfunction

    function automatic void model_beat(input beat_t e, input beat_t a);
        logic       want_last;
        logic       skip_data;
        logic [3:0] mm;
        want_last = (e.user == TU_EOT) && (m_kind == K_CQE);
        skip_data = (e.user == TU_EOT) && (m_kind == K_STATS) && cfg_mask_stats_eot;
        mm = {a.last != want_last, a.strb != e.strb, a.user != e.user,
              (a.data != e.data) && !skip_data};
        m_err = m_err + $countones(mm);
        if (m_err > 65535) m_err = 65535;
        if (mm != 4'h0 && !m_fv) begin
            m_fv      = 1'b1;
            m_fbeat   = m_beats;
            m_ffields = mm;
        end
        m_beats = m_beats + 1;
        if (e.user == TU_EOT) m_frames = m_frames + 1;
        if (e.user == TU_SOT) begin
            if (e.data[7:0] == OP_CQE)        m_kind = K_CQE;
            else if (e.data[7:0] == OP_STATS) m_kind = K_STATS;
            else                              m_kind = K_FRAME;
        end else if (e.user == TU_EOT) begin
            m_kind = K_NONE;
        end
    endfunction

    // Builds one frame; the DUT-side copy carries tlast only on a CQE EoT.
    function automatic void push_frame(input logic [7:0] op, input int nmid);
        beat_t b;
        int    n;
        n = nmid + 2;
        for (int k = 0; k < n; k++) begin
            b.data = {$urandom, $urandom};
            b.strb = 8'hFF;
            if (k == 0) begin
                b.user      = TU_SOT;
                b.data[7:0] = op;
            end else if (k == n - 1) begin
                b.user = TU_EOT;
            end else begin
                b.user = TU_MID;
            end
            b.last = 1'b0;
            eq.push_back(b);
            b.last = (k == n - 1) && (op == OP_CQE);
            aq.push_back(b);
        end
    endfunction

    task automatic drive_seq(input int gmax);
        int  i;
        int  gap;
        int  waits;
        bit  fire;
        i = 0;
        while (i < eq.size()) begin
            gap = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
            repeat (gap) begin
                @(negedge clk);
                exp_tvalid = 1'b0;
                act_tvalid = 1'b0;
            end
            waits = 0;
            fire  = 1'b0;
            while (!fire) begin
                @(negedge clk);
                exp_tvalid = 1'b1;
                exp_tdata  = eq[i].data;
                exp_tstrb  = eq[i].strb;
                exp_tuser  = eq[i].user;
                act_tvalid = 1'b1;
                act_tdata  = aq[i].data;
                act_tstrb  = aq[i].strb;
                act_tuser  = aq[i].user;
                act_tlast  = aq[i].last;
                #1;
                valid_cycles = valid_cycles + 1;
                if (!act_tready) bp_low_cycles = bp_low_cycles + 1;
                if (cfg_bp_thresh == 8'h00) begin
                    total++;
                    if (act_tready !== 1'b1 || exp_tready !== 1'b1) begin
                        bad++;
                        $display("FAIL ready_no_bp: act_tready=%b exp_tready=%b want 1/1", act_tready, exp_tready);
                    end
                end
                fire = act_tready;
                waits = waits + 1;
                if (!fire && waits > 100) begin
                    total++;
                    bad++;
                    $display("FAIL handshake_timeout: beat %0d not accepted in 100 cycles", i);
                    exp_tvalid = 1'b0;
                    act_tvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            model_beat(eq[i], aq[i]);
            i++;
        end
        @(negedge clk);
        exp_tvalid = 1'b0;
        act_tvalid = 1'b0;
    endtask

    task automatic new_run(input logic [7:0] thresh, input logic mask);
        @(negedge clk);
        clear              = 1'b1;
        cfg_bp_thresh      = thresh;
        cfg_mask_stats_eot = mask;
        exp_done           = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        eq.delete();
        aq.delete();
        valid_cycles  = 0;
        bp_low_cycles = 0;
    endtask

    task automatic finish_run();
        repeat (3) @(negedge clk);
        exp_done = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({err_cnt, beat_cnt, frame_cnt, first_err_valid, first_err_beat, first_err_fields,
             wdog_expired, extra_beat, done, pass} !== '0) begin
            bad++;
            $display("FAIL reset_status: err=%0d beats=%0d frames=%0d fev=%b done=%b pass=%b want all 0",
                     err_cnt, beat_cnt, frame_cnt, first_err_valid, done, pass);
        end
        total++;
        if (act_tready !== 1'b0 || exp_tready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: act=%b exp=%b want 0/0", act_tready, exp_tready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_cqe();
        new_run(8'h00, 1'b0);
        push_frame(OP_CQE, 1);
        drive_seq(0);
        finish_run();
        total++;
        if (err_cnt !== 16'd0 || frame_cnt !== 16'd1 || beat_cnt !== 32'd3) begin
            bad++;
            $display("FAIL clean_cqe_counts: err=%0d frames=%0d beats=%0d want 0/1/3", err_cnt, frame_cnt, beat_cnt);
        end
        total++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            bad++;
            $display("FAIL clean_cqe_pass: done=%b pass=%b want 1/1", done, pass);
        end
    endtask

    task automatic test_data_err();
        new_run(8'h00, 1'b0);
        push_frame(OP_CQE, 1);
        aq[1].data[0] = ~aq[1].data[0];
        drive_seq(0);
        finish_run();
        total++;
        if (err_cnt !== 16'(m_err) || err_cnt !== 16'd1) begin
            bad++;
            $display("FAIL data_err_cnt: got %0d want %0d", err_cnt, m_err);
        end
        total++;
        if (first_err_valid !== 1'b1 || first_err_beat !== 32'(m_fbeat) || first_err_fields !== 4'b0001) begin
            bad++;
            $display("FAIL data_err_capture: v=%b beat=%0d fields=%b want 1/%0d/0001",
                     first_err_valid, first_err_beat, first_err_fields, m_fbeat);
        end
        total++;
        if (pass !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL data_err_pass: done=%b pass=%b want 1/0", done, pass);
        end
    endtask

    task automatic test_stats_mask();
        for (int m = 1; m >= 0; m--) begin
            new_run(8'h00, 1'(m));
            push_frame(OP_STATS, 1);
            aq[2].data[8] = ~aq[2].data[8];
            drive_seq(0);
            finish_run();
            total++;
            if (err_cnt !== 16'(m_err) || err_cnt !== 16'(1 - m)) begin
                bad++;
                $display("FAIL stats_mask%0d: err got %0d want %0d", m, err_cnt, 1 - m);
            end
        end
    endtask

    task automatic test_watchdog();
        new_run(8'h00, 1'b0);
        @(negedge clk);
        exp_tvalid = 1'b1;
        exp_tuser  = TU_MID;
        act_tvalid = 1'b0;
        repeat (WDOG - 1) @(posedge clk);
        #1;
        total++;
        if (wdog_expired !== 1'b0) begin
            bad++;
            $display("FAIL wdog_early: expired=%b want 0 after %0d stalls", wdog_expired, WDOG - 1);
        end
        @(posedge clk);
        #1;
        total++;
        if (wdog_expired !== 1'b1) begin
            bad++;
            $display("FAIL wdog_expire: expired=%b want 1 after %0d stalls", wdog_expired, WDOG);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL wdog_done: done=%b pass=%b want 1/0", done, pass);
        end
        @(negedge clk);
        exp_tvalid = 1'b0;
        new_run(8'h00, 1'b0);
        total++;
        if (wdog_expired !== 1'b0) begin
            bad++;
            $display("FAIL wdog_clear: expired=%b want 0", wdog_expired);
        end
    endtask

    task automatic test_backpressure();
        beat_t b;
        int    pct;
        new_run(8'h80, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            b.data = {32'(k), $urandom};
            b.strb = 8'(k);
            b.user = TU_NONE;
            b.last = 1'b0;
            eq.push_back(b);
            aq.push_back(b);
        end
        drive_seq(0);
        finish_run();
        total++;
        if (beat_cnt !== 32'd1000 || m_beats != 1000) begin
            bad++;
            $display("FAIL bp_beats: got %0d want 1000", beat_cnt);
        end
        total++;
        if (err_cnt !== 16'd0 || pass !== 1'b1) begin
            bad++;
            $display("FAIL bp_clean: err=%0d pass=%b want 0/1", err_cnt, pass);
        end
        pct = (bp_low_cycles * 100) / valid_cycles;
        total++;
        if (pct < 35 || pct > 65) begin
            bad++;
            $display("FAIL bp_ratio: ready low on %0d%% of cycles want 35..65", pct);
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        int         n;
        int         idx;
        beat_t      b;
        for (int r = 0; r < 3; r++) begin
            new_run(8'($urandom_range(128, 0)), 1'($urandom_range(1, 0)));
            for (int f = 0; f < 20; f++) begin
                case ($urandom_range(2, 0))
                    0:       op = OP_CQE;
                    1:       op = OP_STATS;
                    default: op = 8'h10 + 8'($urandom_range(200, 0));
                endcase
                n = int'($urandom_range(3, 0));
                push_frame(op, n);
                if ($urandom_range(3, 0) == 0) begin
                    idx = aq.size() - 1 - int'($urandom_range(n + 1, 0));
                    case ($urandom_range(3, 0))
                        0:       aq[idx].data = aq[idx].data ^ (64'd1 << $urandom_range(63, 0));
                        1:       aq[idx].user = aq[idx].user ^ 8'h04;
                        2:       aq[idx].strb = aq[idx].strb ^ 8'h01;
                        default: aq[idx].last = ~aq[idx].last;
                    endcase
                end
                if ($urandom_range(3, 0) == 0) begin
                    b.data = {$urandom, $urandom};
                    b.strb = 8'hFF;
                    b.user = TU_NONE;
                    b.last = 1'b0;
                    eq.push_back(b);
                    aq.push_back(b);
                end
            end
            drive_seq(2);
            finish_run();
            total++;
            if (err_cnt !== 16'(m_err) || beat_cnt !== 32'(m_beats) || frame_cnt !== 16'(m_frames)) begin
                bad++;
                $display("FAIL rand%0d_counts: err=%0d beats=%0d frames=%0d want %0d/%0d/%0d",
                         r, err_cnt, beat_cnt, frame_cnt, m_err, m_beats, m_frames);
            end
            total++;
            if (first_err_valid !== m_fv ||
                (m_fv && (first_err_beat !== 32'(m_fbeat) || first_err_fields !== m_ffields))) begin
                bad++;
                $display("FAIL rand%0d_first: v=%b beat=%0d fields=%b want %b/%0d/%b",
                         r, first_err_valid, first_err_beat, first_err_fields, m_fv, m_fbeat, m_ffields);
            end
            total++;
            if (done !== 1'b1 || pass !== (m_err == 0)) begin
                bad++;
                $display("FAIL rand%0d_pass: done=%b pass=%b want 1/%b", r, done, pass, m_err == 0);
            end
        end
    endtask

    task automatic test_midframe_reset();
        beat_t b;
        new_run(8'h00, 1'b0);
        push_frame(OP_CQE, 1);
        void'(eq.pop_back());
        void'(aq.pop_back());
        drive_seq(0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        eq.delete();
        aq.delete();
        b.data = {$urandom, $urandom};
        b.strb = 8'hFF;
        b.user = TU_EOT;
        b.last = 1'b0;
        eq.push_back(b);
        aq.push_back(b);
        drive_seq(0);
        finish_run();
        total++;
        if (err_cnt !== 16'(m_err) || err_cnt !== 16'd0 || beat_cnt !== 32'd1 || frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL midframe_reset: err=%0d beats=%0d frames=%0d want 0/1/1", err_cnt, beat_cnt, frame_cnt);
        end
    endtask

    task automatic test_extra_beat();
        new_run(8'h00, 1'b0);
        @(negedge clk);
        exp_done   = 1'b1;
        exp_tvalid = 1'b0;
        act_tvalid = 1'b1;
        #1;
        total++;
        if (exp_tready !== 1'b0 || act_tready !== 1'b0) begin
            bad++;
            $display("FAIL extra_no_pop: exp_tready=%b act_tready=%b want 0/0", exp_tready, act_tready);
        end
        @(negedge clk);
        act_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (extra_beat !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin
            bad++;
            $display("FAIL extra_beat: flag=%b done=%b pass=%b want 1/1/0", extra_beat, done, pass);
        end
        new_run(8'h00, 1'b0);
        total++;
        if (extra_beat !== 1'b0) begin
            bad++;
            $display("FAIL extra_clear: flag=%b want 0", extra_beat);
        end
    endtask

    task automatic test_saturation();
        beat_t e;
        beat_t a;
        new_run(8'h00, 1'b0);
        e.data = '0;
        e.strb = 8'hFF;
        e.user = TU_NONE;
        e.last = 1'b0;
        a.data = 64'd1;
        a.strb = 8'h00;
        a.user = TU_MID;
        a.last = 1'b1;
        for (int k = 0; k < 16383; k++) begin
            eq.push_back(e);
            aq.push_back(a);
        end
        drive_seq(0);
        repeat (4) @(negedge clk);
        total++;
        if (err_cnt !== 16'(m_err) || err_cnt !== 16'd65532) begin
            bad++;
            $display("FAIL sat_pre: err=%0d want %0d", err_cnt, m_err);
        end
        eq.delete();
        aq.delete();
        for (int k = 0; k < 2; k++) begin
            eq.push_back(e);
            aq.push_back(a);
        end
        drive_seq(0);
        repeat (4) @(negedge clk);
        total++;
        if (err_cnt !== 16'(m_err) || err_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_hold: err=%0d want %0d", err_cnt, m_err);
        end
        total++;
        if (first_err_beat !== 32'd0 || first_err_fields !== 4'b1111 || beat_cnt !== 32'd16385) begin
            bad++;
            $display("FAIL sat_capture: beat=%0d fields=%b beats=%0d want 0/1111/16385",
                     first_err_beat, first_err_fields, beat_cnt);
        end
    endtask

    task automatic test_clear_with_beat();
        @(negedge clk);
        clear      = 1'b1;
        exp_tvalid = 1'b1;
        exp_tuser  = TU_EOT;
        exp_tdata  = '0;
        act_tvalid = 1'b1;
        act_tdata  = 64'hFF;
        act_tuser  = TU_SOT;
        act_tlast  = 1'b1;
        #1;
        total++;
        if (exp_tready !== 1'b1) begin
            bad++;
            $display("FAIL clear_beat_pop: exp_tready=%b want 1", exp_tready);
        end
        @(negedge clk);
        clear      = 1'b0;
        exp_tvalid = 1'b0;
        act_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (err_cnt !== 16'd0 || beat_cnt !== 32'd0 || frame_cnt !== 16'd0 || first_err_valid !== 1'b0) begin
            bad++;
            $display("FAIL clear_beat_counts: err=%0d beats=%0d frames=%0d fev=%b want 0/0/0/0",
                     err_cnt, beat_cnt, frame_cnt, first_err_valid);
        end
    endtask

    initial begin
        act_tvalid         = 1'b0;
        act_tdata          = '0;
        act_tstrb          = '0;
        act_tuser          = '0;
        act_tlast          = 1'b0;
        exp_tvalid         = 1'b0;
        exp_tdata          = '0;
        exp_tstrb          = '0;
        exp_tuser          = '0;
        exp_done           = 1'b0;
        cfg_bp_thresh      = 8'h00;
        cfg_mask_stats_eot = 1'b0;
        clear              = 1'b0;
        valid_cycles       = 0;
        bp_low_cycles      = 0;
        model_reset();

        test_reset();
        test_clean_cqe();
        test_data_err();
        test_stats_mask();
        test_watchdog();
        test_backpressure();
        test_random();
        test_midframe_reset();
        test_extra_beat();
        test_saturation();
        test_clear_with_beat();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900us;
        $display("FAIL global_timeout: simulation exceeded 900us");
        $fatal(1, "timeout");
    end

endmodule
